// File: rtl/dz_scan_decoder.sv
// Decodes a multiplexed red/green 8x8 dot-matrix scan back into a frame buffer.
// It also reports frame stability, a colour class, the lit-pixel count and scan errors.
module dz_scan_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] row,
  input  logic [7:0] colr,
  input  logic [7:0] colg,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_colr,
  output logic [7:0] rd_colg,
  output logic       frame_valid,
  output logic       frame_stable,
  output logic [2:0] color,
  output logic [6:0] lit_count,
  output logic       err_row,
  output logic       err_seq
);

  typedef enum logic {HUNT, CAPTURE} state_t;

  state_t      state, state_n;
  logic [2:0]  exp, exp_n;
  logic [6:0]  acc, acc_n;
  logic        ro_seen, ro_seen_n;
  logic        go_seen, go_seen_n;
  logic        bo_seen, bo_seen_n;
  logic        commit_pend, commit_n;
  logic        err_row_n, err_seq_n;
  logic        wr_en;
  logic        start;

  logic [63:0] shadow_r, shadow_g;
  logic [63:0] comm_r, comm_g;

  logic [7:0]  zeros;
  logic        legal;
  logic [2:0]  idx;
  logic [3:0]  pc;
  logic        ro_s, go_s, bo_s;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Row is legal only with exactly one low bit; idx is that bit's position.
  always_comb begin
    zeros = ~row;
    legal = (zeros != 8'h00) && ((zeros & (zeros - 8'h01)) == 8'h00);
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!row[i]) idx = i[2:0];
    end
    pc   = popcount8(colr | colg);
    ro_s = |(colr & ~colg);
    go_s = |(colg & ~colr);
    bo_s = |(colr & colg);
  end

  always_comb begin
    state_n   = state;
    exp_n     = exp;
    acc_n     = acc;
    ro_seen_n = ro_seen;
    go_seen_n = go_seen;
    bo_seen_n = bo_seen;
    wr_en     = 1'b0;
    start     = 1'b0;
    commit_n  = 1'b0;
    err_row_n = 1'b0;
    err_seq_n = 1'b0;

    if (!legal) begin
      err_row_n = 1'b1;
      state_n   = HUNT;
      exp_n     = 3'd0;
    end else begin
      case (state)
        HUNT: begin
          if (idx == 3'd0) start = 1'b1;
        end
        CAPTURE: begin
          if (idx == exp) begin
            wr_en     = 1'b1;
            acc_n     = acc + {3'b000, pc};
            ro_seen_n = ro_seen | ro_s;
            go_seen_n = go_seen | go_s;
            bo_seen_n = bo_seen | bo_s;
            if (exp == 3'd7) begin
              commit_n = 1'b1;
              state_n  = HUNT;
              exp_n    = 3'd0;
            end else begin
              exp_n = exp + 3'd1;
            end
          end else begin
            err_seq_n = 1'b1;
            if (idx == 3'd0) begin
              start = 1'b1;
            end else begin
              state_n = HUNT;
              exp_n   = 3'd0;
            end
          end
        end
        default: begin
          state_n = HUNT;
          exp_n   = 3'd0;
        end
      endcase
    end

    // Row 0 (re)starts a frame: the accumulator and flags restart from this sample.
    if (start) begin
      wr_en     = 1'b1;
      acc_n     = {3'b000, pc};
      ro_seen_n = ro_s;
      go_seen_n = go_s;
      bo_seen_n = bo_s;
      exp_n     = 3'd1;
      state_n   = CAPTURE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      exp         <= 3'd0;
      acc         <= 7'd0;
      ro_seen     <= 1'b0;
      go_seen     <= 1'b0;
      bo_seen     <= 1'b0;
      commit_pend <= 1'b0;
      err_row     <= 1'b0;
      err_seq     <= 1'b0;
      shadow_r    <= 64'd0;
      shadow_g    <= 64'd0;
    end else begin
      state       <= state_n;
      exp         <= exp_n;
      acc         <= acc_n;
      ro_seen     <= ro_seen_n;
      go_seen     <= go_seen_n;
      bo_seen     <= bo_seen_n;
      commit_pend <= commit_n;
      err_row     <= err_row_n;
      err_seq     <= err_seq_n;
      if (wr_en) begin
        shadow_r[{idx, 3'b000} +: 8] <= colr;
        shadow_g[{idx, 3'b000} +: 8] <= colg;
      end
    end
  end

  // Commit reads the pre-edge shadow, accumulator and flags, so a new frame may start on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comm_r       <= 64'd0;
      comm_g       <= 64'd0;
      frame_valid  <= 1'b0;
      frame_stable <= 1'b0;
      color        <= 3'd0;
      lit_count    <= 7'd0;
    end else begin
      frame_valid <= commit_pend;
      if (commit_pend) begin
        comm_r       <= shadow_r;
        comm_g       <= shadow_g;
        lit_count    <= acc;
        frame_stable <= (shadow_r == comm_r) && (shadow_g == comm_g);
        case ({ro_seen, go_seen, bo_seen})
          3'b000:  color <= 3'd0;
          3'b100:  color <= 3'd1;
          3'b010:  color <= 3'd2;
          3'b001:  color <= 3'd3;
          default: color <= 3'd4;
        endcase
      end
    end
  end

  assign rd_colr = comm_r[{rd_row, 3'b000} +: 8];
  assign rd_colg = comm_g[{rd_row, 3'b000} +: 8];

endmodule

// File: tb/tb_dz_scan_decoder.sv
// Directed self-checking bench for dz_scan_decoder; inputs change on negedge,
// outputs are checked 1 time unit after the capturing posedge.
module tb_dz_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] row, colr, colg;
  logic [2:0] rd_row;
  logic [7:0] rd_colr, rd_colg;
  logic       frame_valid, frame_stable;
  logic [2:0] color;
  logic [6:0] lit_count;
  logic       err_row, err_seq;

  int testCount = 0;
  int failCount = 0;

  dz_scan_decoder dut (
    .clk(clk), .rst(rst), .row(row), .colr(colr), .colg(colg),
    .rd_row(rd_row), .rd_colr(rd_colr), .rd_colg(rd_colg),
    .frame_valid(frame_valid), .frame_stable(frame_stable),
    .color(color), .lit_count(lit_count),
    .err_row(err_row), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rowSel(input int i);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << i);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // One sample: drive on negedge, return just after the capturing posedge.
  task automatic applyStimulus(input logic [7:0] rv, input logic [7:0] r, input logic [7:0] g);
    @(negedge clk);
    row  = rv;
    colr = r;
    colg = g;
    @(posedge clk);
    #1;
  endtask

  // Legal row 5 is ignored in HUNT, so it serves as an idle sample.
  task automatic idle();
    applyStimulus(rowSel(5), 8'h00, 8'h00);
  endtask

  initial begin
    rst = 1'b1; row = 8'hFF; colr = 8'h00; colg = 8'h00; rd_row = 3'd0;
    #12;
    checkOutput("reset_fv", {31'd0, frame_valid}, 32'd0);
    checkOutput("reset_lit", {25'd0, lit_count}, 32'd0);
    checkOutput("reset_color", {29'd0, color}, 32'd0);
    checkOutput("reset_errrow", {31'd0, err_row}, 32'd0);
    @(negedge clk);
    row = rowSel(5);
    rst = 1'b0;

    // Scenario 1: single green row
    for (int i = 0; i < 8; i++) applyStimulus(rowSel(i), 8'h00, (i == 1) ? 8'h18 : 8'h00);
    checkOutput("s1_fv_early", {31'd0, frame_valid}, 32'd0);
    idle();
    rd_row = 3'd1; #1;
    checkOutput("s1_fv", {31'd0, frame_valid}, 32'd1);
    checkOutput("s1_color", {29'd0, color}, 32'd2);
    checkOutput("s1_lit", {25'd0, lit_count}, 32'd2);
    checkOutput("s1_rdg", {24'd0, rd_colg}, 32'h18);
    checkOutput("s1_rdr", {24'd0, rd_colr}, 32'h00);
    checkOutput("s1_stable", {31'd0, frame_stable}, 32'd0);
    idle();
    checkOutput("s1_fv_pulse", {31'd0, frame_valid}, 32'd0);

    // Scenario 2: two back-to-back identical yellow frames
    for (int i = 0; i < 8; i++) applyStimulus(rowSel(i), (i == 0) ? 8'h00 : 8'h3C, (i == 0) ? 8'h00 : 8'h3C);
    applyStimulus(rowSel(0), 8'h00, 8'h00);
    checkOutput("s2_fv1", {31'd0, frame_valid}, 32'd1);
    checkOutput("s2_stable1", {31'd0, frame_stable}, 32'd0);
    checkOutput("s2_color1", {29'd0, color}, 32'd3);
    checkOutput("s2_lit1", {25'd0, lit_count}, 32'd28);
    for (int i = 1; i < 8; i++) applyStimulus(rowSel(i), 8'h3C, 8'h3C);
    idle();
    checkOutput("s2_fv2", {31'd0, frame_valid}, 32'd1);
    checkOutput("s2_stable2", {31'd0, frame_stable}, 32'd1);
    checkOutput("s2_lit2", {25'd0, lit_count}, 32'd28);

    // Scenario 3: out-of-order row aborts, then a normal red frame
    applyStimulus(rowSel(0), 8'hFF, 8'h00);
    applyStimulus(rowSel(1), 8'hFF, 8'h00);
    applyStimulus(rowSel(2), 8'hFF, 8'h00);
    applyStimulus(rowSel(4), 8'hFF, 8'h00);
    checkOutput("s3_errseq", {31'd0, err_seq}, 32'd1);
    checkOutput("s3_errrow", {31'd0, err_row}, 32'd0);
    for (int i = 5; i < 8; i++) applyStimulus(rowSel(i), 8'hFF, 8'h00);
    idle();
    checkOutput("s3_errseq_pulse", {31'd0, err_seq}, 32'd0);
    checkOutput("s3_fv", {31'd0, frame_valid}, 32'd0);
    checkOutput("s3_color_kept", {29'd0, color}, 32'd3);
    checkOutput("s3_lit_kept", {25'd0, lit_count}, 32'd28);
    checkOutput("s3_stable_kept", {31'd0, frame_stable}, 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(rowSel(i), (i == 2) ? 8'h81 : 8'h00, 8'h00);
    idle();
    checkOutput("s3_fv_after", {31'd0, frame_valid}, 32'd1);
    checkOutput("s3_color_after", {29'd0, color}, 32'd1);
    checkOutput("s3_lit_after", {25'd0, lit_count}, 32'd2);
    checkOutput("s3_stable_after", {31'd0, frame_stable}, 32'd0);

    // Scenario 4: illegal patterns mid-frame
    for (int i = 0; i < 3; i++) applyStimulus(rowSel(i), 8'hFF, 8'hFF);
    applyStimulus(8'hFF, 8'hFF, 8'hFF);
    checkOutput("s4_errrow_ff", {31'd0, err_row}, 32'd1);
    for (int i = 3; i < 8; i++) applyStimulus(rowSel(i), 8'hFF, 8'hFF);
    checkOutput("s4_errrow_pulse", {31'd0, err_row}, 32'd0);
    idle();
    checkOutput("s4_fv_ff", {31'd0, frame_valid}, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(rowSel(i), 8'hFF, 8'hFF);
    applyStimulus(8'hFC, 8'hFF, 8'hFF);
    checkOutput("s4_errrow_fc", {31'd0, err_row}, 32'd1);
    for (int i = 4; i < 8; i++) applyStimulus(rowSel(i), 8'hFF, 8'hFF);
    idle();
    checkOutput("s4_fv_fc", {31'd0, frame_valid}, 32'd0);
    checkOutput("s4_lit_kept", {25'd0, lit_count}, 32'd2);
    checkOutput("s4_color_kept", {29'd0, color}, 32'd1);

    // Scenario 5: mixed frame, then all-lit frame
    for (int i = 0; i < 8; i++) applyStimulus(rowSel(i), (i == 0) ? 8'h01 : 8'h00, (i == 1) ? 8'h01 : 8'h00);
    idle();
    checkOutput("s5_color_mixed", {29'd0, color}, 32'd4);
    checkOutput("s5_lit_mixed", {25'd0, lit_count}, 32'd2);
    for (int i = 0; i < 8; i++) applyStimulus(rowSel(i), 8'hFF, 8'hFF);
    idle();
    rd_row = 3'd7; #1;
    checkOutput("s5_lit_full", {25'd0, lit_count}, 32'd64);
    checkOutput("s5_color_full", {29'd0, color}, 32'd3);
    checkOutput("s5_rdr_full", {24'd0, rd_colr}, 32'hFF);

    // Scenario 6: asynchronous reset during row 5
    for (int i = 0; i < 5; i++) applyStimulus(rowSel(i), 8'hFF, 8'hFF);
    @(negedge clk);
    row = rowSel(5); colr = 8'hFF; colg = 8'hFF;
    #2 rst = 1'b1;
    #1;
    checkOutput("s6_rst_lit", {25'd0, lit_count}, 32'd0);
    checkOutput("s6_rst_color", {29'd0, color}, 32'd0);
    checkOutput("s6_rst_stable", {31'd0, frame_stable}, 32'd0);
    checkOutput("s6_rst_rdr", {24'd0, rd_colr}, 32'd0);
    checkOutput("s6_rst_fv", {31'd0, frame_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(rowSel(6), 8'hFF, 8'hFF);
    applyStimulus(rowSel(7), 8'hFF, 8'hFF);
    idle();
    checkOutput("s6_no_commit", {31'd0, frame_valid}, 32'd0);
    checkOutput("s6_lit_zero", {25'd0, lit_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/dz_scan_decoder.md
DZ_SCAN_DECODER -- requirements
Module: dz_scan_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state advances on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port row, input, 8 bits: active-low one-hot row select from the dot-matrix scan driver; bit i low = row i.
REQ-004 SHALL have port colr, input, 8 bits: red column data for the selected row; 1 = lit.
REQ-005 SHALL have port colg, input, 8 bits: green column data for the selected row; 1 = lit.
REQ-006 SHALL have port rd_row, input, 3 bits: read address into the committed frame.
REQ-007 SHALL have port rd_colr, output, 8 bits: committed red data for rd_row, combinational.
REQ-008 SHALL have port rd_colg, output, 8 bits: committed green data for rd_row, combinational.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse on each frame commit.
REQ-010 SHALL have port frame_stable, output, 1 bit: last committed frame equals the previous committed frame.
REQ-011 SHALL have port color, output, 3 bits: committed-frame colour class.
REQ-012 SHALL have port lit_count, output, 7 bits: committed-frame count of lit pixels, range 0..64.
REQ-013 SHALL have port err_row, output, 1 bit: one-cycle pulse on an illegal row pattern.
REQ-014 SHALL have port err_seq, output, 1 bit: one-cycle pulse on an out-of-order row.

Function
REQ-015 SHALL sample row, colr and colg on every clk edge; the row and column inputs of a sample are aligned in the same cycle.
REQ-016 SHALL treat row as legal only when exactly one bit is 0; the row index is the position of that 0 bit.
REQ-017 SHALL implement FSM states HUNT and CAPTURE, plus an expected-row counter exp[2:0].
REQ-018 In HUNT, a legal row index 0 SHALL write colr/colg into shadow row 0, set exp=1, set the accumulator to popcount(colr|colg) of that sample, and enter CAPTURE; any other legal index SHALL be ignored.
REQ-019 In CAPTURE, a legal index equal to exp SHALL write shadow row exp, add popcount(colr|colg) to a 7-bit accumulator, and increment exp.
REQ-020 When CAPTURE writes index 7, the FSM SHALL commit the frame on the next edge (shadow to committed buffer, accumulator to lit_count, frame_valid=1 for one cycle) and return to HUNT.
REQ-021 The commit cycle SHALL still evaluate that cycle's sample as HUNT does, so back-to-back frames are captured with no gap.
REQ-022 In CAPTURE, a legal index not equal to exp SHALL pulse err_seq; if the index is 0 the FSM SHALL restart capture as in REQ-018, otherwise it SHALL go to HUNT.
REQ-023 An illegal row pattern (all ones, or two or more zeros) SHALL pulse err_row in the next cycle in any state, abort any capture, and go to HUNT.
REQ-024 Aborted captures SHALL leave the committed buffer, color, lit_count and frame_stable unchanged.
REQ-025 On commit, frame_stable SHALL be set to 1 if the new shadow equals the old committed buffer in all 128 bits, else 0.
REQ-026 On commit, color SHALL be set by pixel classes:
- 0 = blank (no pixel lit).
- 1 = red (every lit pixel is red-only).
- 2 = green (every lit pixel is green-only).
- 3 = yellow (every lit pixel is both red and green).
- 4 = mixed (any other combination).
REQ-027 Per-pixel class flags (red-only seen, green-only seen, both seen) SHALL accumulate during capture alongside lit_count.
REQ-028 lit_count SHALL be 64 for an all-lit frame; the 7-bit accumulator never overflows.
REQ-029 All outputs except rd_colr/rd_colg SHALL be registered.

Reset
REQ-030 rst SHALL immediately force the following values:
- State: FSM=HUNT, exp=0, accumulator and class flags 0.
- Buffers: shadow and committed buffers all 0.
- Outputs: frame_valid=0, frame_stable=0, color=0, lit_count=0, err_row=0, err_seq=0.
REQ-031 Release of rst SHALL take effect on the next clk edge, and a frame already in progress SHALL NOT be committed.

Verification
REQ-032 Scenario 1: scan rows 0..7 with colr=colg=8'h00 except row1 colg=8'h18 -> frame_valid pulse one cycle after the row-7 sample, color=2, lit_count=2, rd_row=1 gives rd_colg=8'h18.
REQ-033 Scenario 2: two identical consecutive yellow frames (rows 1..7 colr=colg=8'h3C) -> first commit frame_stable=0, color=3, lit_count=28; second commit frame_stable=1.
REQ-034 Scenario 3: row sequence 0,1,2,4 -> err_seq pulse at the index-4 sample, no frame_valid, prior committed values unchanged; a following full 0..7 scan commits normally.
REQ-035 Scenario 4: row=8'hFF or 8'hFC mid-frame -> err_row pulse next cycle, FSM in HUNT, no commit.
REQ-036 Scenario 5: row0 colr=8'h01, colg=8'h00 and row1 colg=8'h01, colr=8'h00 -> color=4; an all-lit frame (colr=colg=8'hFF) -> lit_count=64, color=3.
REQ-037 Scenario 6: assert rst during row 5 of a frame -> all outputs 0 immediately; rows 6,7 after release produce no commit.
